// File: rtl/fp_wb_arbiter.sv
// Generic circular-buffer FIFO used for the per-source result queues.
// Latency: a push at edge T is visible on dout in cycle T+1 (registered storage, combinational head).
// Backpressure: none internally; the caller only pushes when not full and only pops when not empty.
module fp_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;

    assign dout = mem[rptr];

    // Pointers and occupancy; flush and reset both empty the queue.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wptr] <= din;
    end
endmodule

// FP writeback completion arbiter: per-source result FIFOs, round-robin grant onto the single FP writeback port.
// Latency: a result accepted at edge T can be written back in cycle T+1 (registered FIFO, combinational read-out).
// Backpressure: src_ready drops while a FIFO is full (no same-cycle pop bypass); wb_stall holds all pops.
module fp_wb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 2,
    parameter int XLEN       = 32,
    parameter int total_regs = 32,
    parameter int AW         = $clog2(total_regs),
    parameter int SW         = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wb_stall,
    input  logic                    fflags_clr,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [NUM_SRC*AW-1:0]   src_rd,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [NUM_SRC*5-1:0]    src_fflags,
    output logic                    FP_reg_write_wb,
    output logic [AW-1:0]           waddr_wb,
    output logic [XLEN-1:0]         wdata_wb,
    output logic [4:0]              fflags_wb,
    output logic [4:0]              fflags_acc,
    output logic [SW-1:0]           wb_src,
    output logic                    pending
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [4:0]      fflags;
    } entry_t;

    entry_t             head [NUM_SRC];
    entry_t             din  [NUM_SRC];
    logic [CW-1:0]      cnt  [NUM_SRC];
    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;

    logic [SW-1:0]      rr;
    logic [SW-1:0]      gidx;
    logic               found;
    logic               grant;
    entry_t             gh;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_ready[k] = (cnt[k] < CW'(DEPTH)) && !reset && !flush;
        assign push[k]      = src_valid[k] && src_ready[k];
        assign pop[k]       = grant && (gidx == SW'(k));
        assign nonempty[k]  = (cnt[k] != '0);

        assign din[k].rd     = src_rd[k*AW +: AW];
        assign din[k].data   = src_data[k*XLEN +: XLEN];
        assign din[k].fflags = src_fflags[k*5 +: 5];

        fp_wb_fifo #(
            .W     ($bits(entry_t)),
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (din[k]),
            .dout  (head[k]),
            .count (cnt[k])
        );
    end

    // Round-robin search over non-empty heads, starting at rr and wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                gidx  = SW'(idx);
            end
        end
    end

    assign grant = found && !wb_stall && !flush && !reset;
    assign gh    = head[gidx];

    assign FP_reg_write_wb = grant;
    assign waddr_wb        = grant ? gh.rd     : '0;
    assign wdata_wb        = grant ? gh.data   : '0;
    assign fflags_wb       = grant ? gh.fflags : '0;
    assign wb_src          = grant ? gidx      : '0;
    assign pending         = |nonempty;

    // Priority pointer moves past the granted source; sticky flags collect every written result.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr         <= '0;
            fflags_acc <= '0;
        end else begin
            if (flush)
                rr <= '0;
            else if (grant)
                rr <= (gidx == SW'(NUM_SRC - 1)) ? '0 : gidx + SW'(1);
            fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | fflags_wb;
        end
    end
endmodule
